// File: rtl/fphub_div_operand_classifier.sv
// Two-stage HUB-format divider operand classifier: tags each operand as Inf/Zero/One/None.
// Optional saturating special-transfer counter enabled by FPHUB_CLASSIFIER_COUNT_EN.
module fphub_div_operand_classifier #(
    parameter int unsigned M            = 23,
    parameter int unsigned E            = 8,
    parameter int unsigned special_case = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [E+M:0]                      X,
    input  logic [E+M:0]                      Y,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [E+M:0]                      X_out,
    output logic [E+M:0]                      Y_out,
    output logic [$clog2(special_case)-1:0]   X_special_case,
    output logic [$clog2(special_case)-1:0]   Y_special_case,
    output logic                              is_special
`ifdef FPHUB_CLASSIFIER_COUNT_EN
    ,
    output logic [15:0]                       special_count
`endif
);

    localparam int unsigned W  = E + M + 1;
    localparam int unsigned CW = $clog2(special_case);

    localparam logic [CW-1:0] CASE_NONE   = CW'(0);
    localparam logic [CW-1:0] CASE_INF_P  = CW'(1);
    localparam logic [CW-1:0] CASE_INF_N  = CW'(2);
    localparam logic [CW-1:0] CASE_ZERO_P = CW'(3);
    localparam logic [CW-1:0] CASE_ZERO_N = CW'(4);
    localparam logic [CW-1:0] CASE_ONE_P  = CW'(5);
    localparam logic [CW-1:0] CASE_ONE_N  = CW'(6);

    // Biased exponent of 1.0
    localparam logic [E-1:0] ONE_EXP = {1'b0, {(E-1){1'b1}}};

    function automatic logic [CW-1:0] classify(input logic [W-1:0] v);
        logic [E+M-1:0] mag;
        logic           neg;
        mag = v[E+M-1:0];
        neg = v[E+M];
        if (&mag)
            classify = neg ? CASE_INF_N : CASE_INF_P;
        else if (mag == '0)
            classify = neg ? CASE_ZERO_N : CASE_ZERO_P;
        else if ((mag[E+M-1:M] == ONE_EXP) && (mag[M-1:0] == '0))
            classify = neg ? CASE_ONE_N : CASE_ONE_P;
        else
            classify = CASE_NONE;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_x_q, s1_x_d;
    logic [W-1:0]  s1_y_q, s1_y_d;
    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  x_out_q, x_out_d;
    logic [W-1:0]  y_out_q, y_out_d;
    logic [CW-1:0] x_code_q, x_code_d;
    logic [CW-1:0] y_code_q, y_code_d;
    logic          special_q, special_d;
    logic [15:0]   count_q, count_d;
    logic          s2_adv;
    logic          accept;
    logic [CW-1:0] x_code_c;
    logic [CW-1:0] y_code_c;

    // Handshake and next-state for both stages
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        x_code_d   = x_code_q;
        y_code_d   = y_code_q;
        special_d  = special_q;
        count_d    = count_q;

        x_code_c   = classify(s1_x_q);
        y_code_c   = classify(s1_y_q);
        s2_adv     = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_adv;
        accept     = in_valid && in_ready;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_x_d     = X;
            s1_y_d     = Y;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                x_out_d   = s1_x_q;
                y_out_d   = s1_y_q;
                x_code_d  = x_code_c;
                y_code_d  = y_code_c;
                special_d = (x_code_c != CASE_NONE) || (y_code_c != CASE_NONE);
            end
        end

        // Saturating count of delivered special pairs
        if (s2_valid_q && out_ready && special_q && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            x_code_q   <= CASE_NONE;
            y_code_q   <= CASE_NONE;
            special_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            x_code_q   <= x_code_d;
            y_code_q   <= y_code_d;
            special_q  <= special_d;
            count_q    <= count_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign X_out          = x_out_q;
    assign Y_out          = y_out_q;
    assign X_special_case = x_code_q;
    assign Y_special_case = y_code_q;
    assign is_special     = special_q;

`ifdef FPHUB_CLASSIFIER_COUNT_EN
    assign special_count = count_q;
`else
    logic unused_count;
    assign unused_count = ^count_q;
`endif

endmodule

// File: tb/tb_fphub_div_operand_classifier.sv
// Randomized bench for fphub_div_operand_classifier against a queue-based reference model.
module tb_fphub_div_operand_classifier;

    localparam int unsigned M  = 23;
    localparam int unsigned E  = 8;
    localparam int unsigned W  = E + M + 1;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  X;
    logic [W-1:0]  Y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  X_out;
    logic [W-1:0]  Y_out;
    logic [CW-1:0] x_code;
    logic [CW-1:0] y_code;
    logic          is_special;
`ifdef FPHUB_CLASSIFIER_COUNT_EN
    logic [15:0]   special_count;
    int            cnt_model = 0;
`endif

    always #5 clk = ~clk;

    fphub_div_operand_classifier dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .X              (X),
        .Y              (Y),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .X_out          (X_out),
        .Y_out          (Y_out),
        .X_special_case (x_code),
        .Y_special_case (y_code),
        .is_special     (is_special)
`ifdef FPHUB_CLASSIFIER_COUNT_EN
        ,
        .special_count  (special_count)
`endif
    );

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           t;
    } item_t;

    item_t        q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    logic         hold   = 1'b0;
    logic [W-1:0] hx, hy;
    logic [CW-1:0] hxc, hyc;
    logic         hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference classification from the field values
    function automatic int ref_code(input logic [W-1:0] v);
        longint unsigned u, mag, expo, man;
        int neg;
        u    = 64'(v);
        neg  = int'(u >> (E + M));
        mag  = u % (64'd1 << (E + M));
        expo = mag >> M;
        man  = mag % (64'd1 << M);
        if (mag == (64'd1 << (E + M)) - 64'd1) return 1 + neg;
        if (mag == 64'd0) return 3 + neg;
        if (expo == (64'd1 << (E - 1)) - 64'd1 && man == 64'd0) return 5 + neg;
        return 0;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       return {s, 31'h7FFF_FFFF};
            1:       return {s, 31'h0};
            2:       return {s, 31'h3F80_0000};
            3:       return {s, 8'h7F, 23'($urandom)};
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard: an accepted pair is visible two cycles later, in order
    always @(negedge clk) begin
        item_t e;
        logic  exp_ov;
        int    xr, yr;
        cyc++;
        if (rst) begin
            q.delete();
            hold = 1'b0;
`ifdef FPHUB_CLASSIFIER_COUNT_EN
            cnt_model = 0;
`endif
        end else begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
`ifdef FPHUB_CLASSIFIER_COUNT_EN
            check("special_count", 64'(special_count), 64'(cnt_model));
`endif
            if (hold && out_valid) begin
                check("hold_x", 64'(X_out), 64'(hx));
                check("hold_y", 64'(Y_out), 64'(hy));
                check("hold_codes", 64'({x_code, y_code, is_special}), 64'({hxc, hyc, hs}));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e  = q.pop_front();
                xr = ref_code(e.x);
                yr = ref_code(e.y);
                check("x_out", 64'(X_out), 64'(e.x));
                check("y_out", 64'(Y_out), 64'(e.y));
                check("x_code", 64'(x_code), 64'(xr));
                check("y_code", 64'(y_code), 64'(yr));
                check("is_special", 64'(is_special), 64'(xr != 0 || yr != 0));
`ifdef FPHUB_CLASSIFIER_COUNT_EN
                if ((xr != 0 || yr != 0) && cnt_model < 65535) cnt_model++;
`endif
            end
            hold = out_valid && !out_ready;
            hx = X_out; hy = Y_out; hxc = x_code; hyc = y_code; hs = is_special;
            if (in_valid && in_ready) q.push_back('{x: X, y: Y, t: cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        X = x; Y = y; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_codes"}, 64'({x_code, y_code, is_special}), 64'd0);
        check({tag, "_data"}, {X_out, Y_out}, 64'd0);
`ifdef FPHUB_CLASSIFIER_COUNT_EN
        check({tag, "_count"}, 64'(special_count), 64'd0);
`endif
        tick();
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        X = 32'h3F80_0000; Y = 32'h0000_0000;
        repeat (2) tick();
        rst = 1'b0; in_valid = 1'b0;
        check_reset_state("reset");

        // +1 / +Inf with exact two-cycle latency
        send(32'h3F80_0000, 32'h7FFF_FFFF);
        @(negedge clk);
        check("lat1_out_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("lat2_out_valid", 64'(out_valid), 64'd1);
        check("lat2_codes", 64'({x_code, y_code, is_special}), 64'({3'd5, 3'd1, 1'b1}));
        tick();

        send(32'h8000_0000, 32'h4049_0FDB);
        send(32'h4049_0FDB, 32'hC000_0000);
        drain();

        // Back-to-back streaming
        for (int i = 0; i < 8; i++) send(rand_op(), rand_op());
        drain();

        // Backpressure: two accepted, third blocked until out_ready rises
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'h0000_0000);
        send(32'hBF80_0000, 32'h1234_5678);
        X = 32'h3F80_0001; Y = 32'h7F80_0000; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        send(32'h3F80_0001, 32'h7F80_0000);
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h7FFF_FFFF, 32'h3F80_0000);
        send(32'h0000_0000, 32'hBF80_0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check_reset_state("midreset");
        repeat (5) tick();

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            X         = rand_op();
            Y         = rand_op();
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

`ifdef FPHUB_CLASSIFIER_COUNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        X = 32'h3F80_0000; Y = 32'h3F80_0000; in_valid = 1'b1; out_ready = 1'b1;
        repeat (65537) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("count_saturated", 64'(special_count), 64'hFFFF);
        tick();
        for (int i = 0; i < 3; i++) send(32'h0000_0000, 32'h0000_0000);
        repeat (4) tick();
        @(negedge clk);
        check("count_holds", 64'(special_count), 64'hFFFF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("count_reset");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fphub_div_operand_classifier.md
FPHUB_DIV_OPERAND_CLASSIFIER -- requirements
Module: fphub_div_operand_classifier

Interface
REQ-001 SHALL have parameter M, default 23, mantissa width.
REQ-002 SHALL have parameter E, default 8, exponent width.
REQ-003 SHALL have parameter special_case, default 7, number of case codes including CASE_NONE; code width CW = $clog2(special_case).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1: operand-pair handshake.
REQ-007 SHALL have ports X input E+M+1 and Y input E+M+1: dividend and divisor in HUB format, sign at bit E+M.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-009 SHALL have ports X_out output E+M+1 and Y_out output E+M+1: operands passed through unchanged.
REQ-010 SHALL have ports X_special_case output CW and Y_special_case output CW: case codes.
REQ-011 SHALL have port is_special output 1: high when either code is not CASE_NONE.
REQ-012 SHALL have port special_count output 16, present only when FPHUB_CLASSIFIER_COUNT_EN is defined.

Function
REQ-013 SHALL encode codes: NONE=0, INF_P=1, INF_N=2, ZERO_P=3, ZERO_N=4, ONE_P=5, ONE_N=6.
REQ-014 SHALL classify an operand as INF when bits [E+M-1:0] are all ones; P/N from sign bit.
REQ-015 SHALL classify as ZERO when bits [E+M-1:0] are all zeros; P/N from sign bit.
REQ-016 SHALL classify as ONE when exponent field equals 2^(E-1)-1 and mantissa field is all zeros; P/N from sign bit.
REQ-017 SHALL classify all other encodings as NONE; INF/ZERO/ONE are mutually exclusive by construction.
REQ-018 SHALL be a two-stage pipeline: stage 1 registers X, Y; stage 2 registers X_out, Y_out, codes, is_special; latency exactly 2 cycles with no stall.
REQ-019 SHALL accept a transfer only on a cycle with in_valid and in_ready both high; deliver only on out_valid and out_ready both high.
REQ-020 SHALL drive in_ready = !stage1_valid | stage1 advancing, where stage 1 advances when !stage2_valid | out_ready.
REQ-021 SHALL sustain one transfer per cycle with out_ready held high (full throughput).
REQ-022 SHALL hold X_out, Y_out, codes, is_special and out_valid stable while out_valid is high and out_ready is low.
REQ-023 SHALL never drop or duplicate a transfer: with both stages full and out_ready low, in_ready SHALL be low.
REQ-024 SHALL, on simultaneous output consumption and input acceptance with both stages full, shift stage 1 to stage 2 and load the new pair into stage 1 in the same cycle.
REQ-025 SHALL make in_ready independent of in_valid (no combinational in_valid to in_ready path).
REQ-026 SHALL preserve transfer order.

Reset
REQ-027 SHALL, on rst high at a clock edge, clear both stage valid flags; out_valid=0, in_ready=1 in the following cycle.
REQ-028 SHALL reset X_out, Y_out to 0, codes to CASE_NONE, is_special to 0, special_count to 0.
REQ-029 SHALL discard in-flight transfers on reset mid-operation; no output transfer after reset until a new input is accepted.
REQ-030 SHALL ignore in_valid during a cycle with rst high.

Configuration
REQ-031 SHALL, with FPHUB_CLASSIFIER_COUNT_EN defined, increment special_count by 1 on every output transfer with is_special=1, saturating at 16'hFFFF.
REQ-032 SHALL, without FPHUB_CLASSIFIER_COUNT_EN, omit special_count port and counter logic; all other behaviour identical.

Verification
REQ-033 Reset then X=32'h3F800000 (+1), Y=32'h7FFFFFFF (+Inf), out_ready=1 -> out_valid 2 cycles later, X code 5, Y code 1, is_special=1.
REQ-034 X=32'h80000000, Y=32'h40490FDB, out_ready=1 -> X code 4, Y code 0, is_special=1; X=32'h40490FDB, Y=32'hC0000000 -> both codes 0, is_special=0.
REQ-035 Stream 8 back-to-back pairs, out_ready=1 -> 8 outputs on consecutive cycles, in order, in_ready never low.
REQ-036 out_ready=0 while sending 3 pairs -> in_ready low after 2 accepted, output held stable; raise out_ready -> all 3 delivered in order, none lost.
REQ-037 Assert rst with both stages full -> next cycle out_valid=0, in_ready=1, codes 0; no stale output thereafter.
REQ-038 With FPHUB_CLASSIFIER_COUNT_EN, preload by 65537 special transfers -> special_count=16'hFFFF and holds; reset -> 0.
